// File: rtl/calib_pkg.sv
// -----------------------------------------------------------------------------
// calib_pkg
// Shared definitions for the calibration pulse generator:
//   - FSM state encoding (state_e), also exported on the debug port
//   - output-select constants SEL_INJ / SEL_EXT
//   - field widths for NPULSE, WIDTH, PERIOD, TRG_DLY and PLS_CNT
//   - regs_t: every state register of the generator in one packed struct,
//     so the whole register set can be replicated and voted as one vector
//   - helpers that turn raw WIDTH/PERIOD settings into effective values
// -----------------------------------------------------------------------------
package calib_pkg;

  localparam int NPULSE_W  = 8;
  localparam int WIDTH_W   = 4;
  localparam int PERIOD_W  = 12;
  localparam int TRG_DLY_W = 8;
  localparam int PLS_CNT_W = 12;

  localparam logic SEL_INJ = 1'b0;
  localparam logic SEL_EXT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_TWAIT = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    state_e                 state;
    logic                   inj;
    logic                   ext;
    logic                   trg;
    logic                   busy;
    logic                   done;
    logic [PLS_CNT_W-1:0]   pls_cnt;
    logic [PERIOD_W-1:0]    phase;     // clocks since the current pulse rose
    logic [NPULSE_W-1:0]    remain;    // pulses still to issue after the current one
    logic                   trg_pend;
    logic [TRG_DLY_W-1:0]   trg_cnt;   // clocks left until TRG_OUT, valid while trg_pend
    logic                   cfg_sel;
    logic [WIDTH_W-1:0]     cfg_width;   // already forced to >= 1
    logic [PERIOD_W-1:0]    cfg_period;  // already clamped to >= width + 1
    logic                   cfg_trg_en;
    logic [TRG_DLY_W-1:0]   cfg_trg_dly;
  } regs_t;

  function automatic logic [WIDTH_W-1:0] eff_width(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? WIDTH_W'(1) : w;
  endfunction

  // The period must leave at least one low clock between pulses.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p,
                                                     input logic [WIDTH_W-1:0]  w_eff);
    logic [PERIOD_W-1:0] min_p;
    min_p = PERIOD_W'(w_eff) + PERIOD_W'(1);
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/calib_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// calib_pulse_gen_if
// Control/status bundle of the calibration pulse generator.
//   master: drives START, ABORT and the train configuration; observes outputs
//   slave : the generator itself
// Request semantics: START is a one-clock request with no ready signal; it is
// taken only while the generator is idle (BUSY = 0 and DONE = 0) and is
// otherwise dropped. The configuration inputs only need to be valid in the
// START cycle. ABORT is level-sampled every clock and wins over START.
// -----------------------------------------------------------------------------
interface calib_pulse_gen_if;
  import calib_pkg::*;

  logic                 START;
  logic                 ABORT;
  logic                 SEL;
  logic [NPULSE_W-1:0]  NPULSE;
  logic [WIDTH_W-1:0]   WIDTH;
  logic [PERIOD_W-1:0]  PERIOD;
  logic                 TRG_EN;
  logic [TRG_DLY_W-1:0] TRG_DLY;

  logic                 INJ_PLS;
  logic                 EXT_PLS;
  logic                 TRG_OUT;
  logic                 BUSY;
  logic                 DONE;
  logic [PLS_CNT_W-1:0] PLS_CNT;

  modport master (
    output START, ABORT, SEL, NPULSE, WIDTH, PERIOD, TRG_EN, TRG_DLY,
    input  INJ_PLS, EXT_PLS, TRG_OUT, BUSY, DONE, PLS_CNT
  );

  modport slave (
    input  START, ABORT, SEL, NPULSE, WIDTH, PERIOD, TRG_EN, TRG_DLY,
    output INJ_PLS, EXT_PLS, TRG_OUT, BUSY, DONE, PLS_CNT
  );
endinterface

// File: rtl/calib_pulse_gen_tmr_vote.sv
// -----------------------------------------------------------------------------
// tmr_vote
// Bitwise 2-of-3 majority voter.
//   i_a, i_b, i_c : the three replicas of a register (W bits each)
//   o_vote        : per-bit majority
// -----------------------------------------------------------------------------
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_vote
);
  assign o_vote = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/calib_pulse_gen.sv
// -----------------------------------------------------------------------------
// calib_pulse_gen
// Generates a train of NPULSE calibration pulses on INJ_PLS or EXT_PLS, each
// WIDTH clocks high and spaced PERIOD clocks rise-to-rise, with an optional
// one-clock TRG_OUT TRG_DLY clocks after every rise.
//   CLK40       : 40 MHz clock, rising edge
//   RST_RESYNC  : asynchronous active-high reset
//   bus         : calib_pulse_gen_if.slave (START/ABORT/config in, pulses/status out)
//   o_dbg_state : current FSM state
// Parameter TMR = 1 keeps three copies of every state register and feeds the
// bitwise majority back into the next-state logic, so a single upset is
// corrected on the following clock.
// -----------------------------------------------------------------------------
module calib_pulse_gen
  import calib_pkg::*;
#(
  parameter bit TMR = 1'b0
) (
  input  logic               CLK40,
  input  logic               RST_RESYNC,
  calib_pulse_gen_if.slave   bus,
  output state_e             o_dbg_state
);

  localparam int NREP = TMR ? 3 : 1;
  localparam int RW   = $bits(regs_t);

  regs_t          r_rep [NREP];
  regs_t          w_q;
  regs_t          w_d;
  logic           w_fire;
  logic           w_rise;

  generate
    if (TMR) begin : g_tmr
      logic [RW-1:0] w_vote;
      tmr_vote #(.W(RW)) u_vote (
        .i_a    (r_rep[0]),
        .i_b    (r_rep[1]),
        .i_c    (r_rep[2]),
        .o_vote (w_vote)
      );
      assign w_q = regs_t'(w_vote);
    end else begin : g_single
      assign w_q = r_rep[0];
    end
  endgenerate

  // Next-state and next-output computation, always from the voted value.
  always_comb begin
    w_d      = w_q;
    w_fire   = 1'b0;
    w_rise   = 1'b0;
    w_d.trg  = 1'b0;
    w_d.done = 1'b0;

    if (bus.ABORT) begin
      // Pulse counter survives an abort; everything else goes quiet.
      w_d.state    = ST_IDLE;
      w_d.trg_pend = 1'b0;
      w_d.phase    = '0;
      w_d.remain   = '0;
    end else begin
      if (w_q.trg_pend) begin
        if (w_q.trg_cnt == TRG_DLY_W'(1)) begin
          w_fire       = 1'b1;
          w_d.trg_pend = 1'b0;
        end else begin
          w_d.trg_cnt = w_q.trg_cnt - TRG_DLY_W'(1);
        end
      end

      unique case (w_q.state)
        ST_IDLE: begin
          if (bus.START) begin
            w_d.cfg_sel     = bus.SEL;
            w_d.cfg_width   = eff_width(bus.WIDTH);
            w_d.cfg_period  = eff_period(bus.PERIOD, eff_width(bus.WIDTH));
            w_d.cfg_trg_en  = bus.TRG_EN;
            w_d.cfg_trg_dly = bus.TRG_DLY;
            if (bus.NPULSE == '0) begin
              w_d.state = ST_FIN;
            end else begin
              w_rise     = 1'b1;
              w_d.remain = bus.NPULSE - NPULSE_W'(1);
            end
          end
        end
        ST_HIGH: begin
          w_d.phase = w_q.phase + PERIOD_W'(1);
          if (w_q.phase == PERIOD_W'(w_q.cfg_width) - PERIOD_W'(1))
            w_d.state = ST_LOW;
        end
        ST_LOW: begin
          // After the last pulse only one low clock is spent before ending.
          if (w_q.remain == '0) begin
            w_d.state = w_q.trg_pend ? ST_TWAIT : ST_FIN;
          end else if (w_q.phase == w_q.cfg_period - PERIOD_W'(1)) begin
            w_rise     = 1'b1;
            w_d.remain = w_q.remain - NPULSE_W'(1);
          end else begin
            w_d.phase = w_q.phase + PERIOD_W'(1);
          end
        end
        ST_TWAIT: begin
          // Leave once the trigger has been emitted (pending has cleared).
          if (!w_q.trg_pend) w_d.state = ST_FIN;
        end
        ST_FIN:  w_d.state = ST_IDLE;
        default: w_d.state = ST_IDLE;
      endcase

      // A rise restarts the trigger delay; an older pending trigger that
      // has not fired by now is dropped.
      if (w_rise) begin
        w_d.state   = ST_HIGH;
        w_d.phase   = '0;
        w_d.pls_cnt = w_q.pls_cnt + PLS_CNT_W'(1);
        if (w_d.cfg_trg_en) begin
          if (w_d.cfg_trg_dly == '0) begin
            w_fire       = 1'b1;
            w_d.trg_pend = 1'b0;
          end else begin
            w_d.trg_pend = 1'b1;
            w_d.trg_cnt  = w_d.cfg_trg_dly;
          end
        end
      end
    end

    w_d.trg  = w_fire;
    w_d.inj  = (w_d.state == ST_HIGH) && (w_d.cfg_sel == SEL_INJ);
    w_d.ext  = (w_d.state == ST_HIGH) && (w_d.cfg_sel == SEL_EXT);
    w_d.busy = (w_d.state == ST_HIGH) || (w_d.state == ST_LOW) || (w_d.state == ST_TWAIT);
    w_d.done = (w_d.state == ST_FIN);
  end

  always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      for (int i = 0; i < NREP; i++) r_rep[i] <= '0;
    end else begin
      for (int i = 0; i < NREP; i++) r_rep[i] <= w_d;
    end
  end

  assign bus.INJ_PLS  = w_q.inj;
  assign bus.EXT_PLS  = w_q.ext;
  assign bus.TRG_OUT  = w_q.trg;
  assign bus.BUSY     = w_q.busy;
  assign bus.DONE     = w_q.done;
  assign bus.PLS_CNT  = w_q.pls_cnt;
  assign o_dbg_state  = w_q.state;

endmodule

// File: tb/tb_calib_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_calib_pulse_gen
// Self-checking bench for calib_pulse_gen. For every train an independent
// arithmetic model pushes the expected per-clock output vector
// {state, INJ, EXT, TRG, BUSY, DONE, PLS_CNT} into exp_q; the driver pops
// and compares one entry per clock on the falling edge.
// -----------------------------------------------------------------------------
module tb_calib_pulse_gen;
  import calib_pkg::*;

  logic   CLK40 = 1'b0;
  logic   RST_RESYNC;
  state_e dbg_state;

  calib_pulse_gen_if bus();

  calib_pulse_gen #(.TMR(1'b1)) dut (
    .CLK40       (CLK40),
    .RST_RESYNC  (RST_RESYNC),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 CLK40 = ~CLK40;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------- scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  int          train_id = 0;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk(input state_e st, input logic inj, input logic ext,
                                     input logic trg, input logic busy, input logic done,
                                     input int cnt);
    return {st, inj, ext, trg, busy, done, cnt[11:0]};
  endfunction

  function automatic logic [19:0] sample();
    return {dbg_state, bus.INJ_PLS, bus.EXT_PLS, bus.TRG_OUT, bus.BUSY, bus.DONE, bus.PLS_CNT};
  endfunction

  function automatic int rise_cnt(input int n, input int peff, input int c);
    int r;
    if (n == 0 || c < 1) return 0;
    r = (c - 1) / peff + 1;
    return (r < n) ? r : n;
  endfunction

  // Expected vectors for clocks 1..end after the START clock. abort_at >= 0
  // means ABORT is driven in that clock (0 = together with START).
  task automatic push_train(input int n, input int w, input int p, input bit sel,
                            input bit ten, input int dly, input int abort_at);
    int weff, peff, r_last, low_c, done_c, total, rj;
    logic in_pulse, trg_b;
    state_e st;
    weff = (w == 0) ? 1 : w;
    peff = (p < weff + 1) ? weff + 1 : p;
    if (n == 0) begin
      done_c = 1;
      low_c  = 0;
    end else begin
      r_last = 1 + (n - 1) * peff;
      low_c  = r_last + weff;
      done_c = (ten && dly > weff) ? r_last + dly + 1 : low_c + 1;
    end
    total = (abort_at >= 0) ? abort_at + 2 : done_c + 1;
    for (int c = 1; c <= total; c++) begin
      if (abort_at >= 0 && c > abort_at) begin
        exp_q.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           m_cnt + rise_cnt(n, peff, abort_at)));
      end else begin
        in_pulse = (n > 0) && (((c - 1) / peff) < n) && (((c - 1) % peff) < weff);
        trg_b = 1'b0;
        if (ten) begin
          for (int j = 0; j < n; j++) begin
            rj = 1 + j * peff;
            if ((j == n - 1 || dly <= peff) && c == rj + dly) trg_b = 1'b1;
          end
        end
        if (c > done_c)       st = ST_IDLE;
        else if (c == done_c) st = ST_FIN;
        else if (in_pulse)    st = ST_HIGH;
        else if (c <= low_c)  st = ST_LOW;
        else                  st = ST_TWAIT;
        exp_q.push_back(mk(st, in_pulse && !sel, in_pulse && sel, trg_b,
                           c < done_c, c == done_c, m_cnt + rise_cnt(n, peff, c)));
      end
    end
    m_cnt = (m_cnt + ((abort_at >= 0) ? rise_cnt(n, peff, abort_at) : n)) % 4096;
  endtask

  // --------------------------------------------------------------- driver
  // stop_at > 0 stops comparing after that clock (used before a reset).
  // poke re-asserts START mid-train, which must be ignored.
  task automatic run_train(input int n, input int w, input int p, input bit sel,
                           input bit ten, input int dly, input int abort_at,
                           input int stop_at, input bit poke);
    int cyc;
    train_id++;
    push_train(n, w, p, sel, ten, dly, abort_at);
    @(negedge CLK40);
    bus.NPULSE  = n[7:0];
    bus.WIDTH   = w[3:0];
    bus.PERIOD  = p[11:0];
    bus.SEL     = sel;
    bus.TRG_EN  = ten;
    bus.TRG_DLY = dly[7:0];
    bus.START   = 1'b1;
    bus.ABORT   = (abort_at == 0);
    @(negedge CLK40);
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    // Configuration changes after START must not affect the train.
    bus.NPULSE  = 8'($urandom_range(0, 255));
    bus.WIDTH   = 4'($urandom_range(0, 15));
    bus.PERIOD  = 12'($urandom_range(0, 4095));
    bus.SEL     = ~sel;
    bus.TRG_EN  = ~ten;
    bus.TRG_DLY = 8'($urandom_range(0, 255));
    cyc = 1;
    while (exp_q.size() > 0) begin
      if (stop_at > 0 && cyc > stop_at) begin
        exp_q.delete();
        break;
      end
      check_eq($sformatf("train%0d_c%0d", train_id, cyc), 32'(sample()), 32'(exp_q.pop_front()));
      bus.ABORT = (cyc == abort_at);
      bus.START = poke && (cyc == 3);
      @(negedge CLK40);
      cyc++;
    end
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
  endtask

  // ----------------------------------------------------------------- main
  initial begin
    int n, w, p, dly;
    bit sel, ten;
    RST_RESYNC  = 1'b1;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.SEL     = 1'b0;
    bus.NPULSE  = '0;
    bus.WIDTH   = '0;
    bus.PERIOD  = '0;
    bus.TRG_EN  = 1'b0;
    bus.TRG_DLY = '0;
    repeat (3) @(negedge CLK40);
    check_eq("reset_state", 32'(sample()), 32'(mk(ST_IDLE, 0, 0, 0, 0, 0, 0)));
    RST_RESYNC = 1'b0;
    @(negedge CLK40);

    // Reference trains
    run_train(3, 2, 10, 1'b0, 1'b0, 0, -1, 0, 1'b0);
    run_train(1, 1, 5,  1'b1, 1'b1, 6, -1, 0, 1'b0);
    run_train(4, 8, 3,  1'b0, 1'b0, 0, -1, 0, 1'b0);
    // NPULSE = 0, WIDTH = 0 / PERIOD clamp, zero trigger delay
    run_train(0, 5, 7,  1'b1, 1'b1, 2, -1, 0, 1'b0);
    run_train(3, 0, 0,  1'b1, 1'b1, 0, -1, 0, 1'b1);
    // Trigger delay longer than the period: only the last trigger survives
    run_train(3, 2, 4,  1'b0, 1'b1, 5, -1, 0, 1'b1);
    // Trigger delay equal to the period
    run_train(2, 1, 3,  1'b1, 1'b1, 3, -1, 0, 1'b0);

    // Abort mid-train, then a fresh START; abort together with START
    run_train(10, 2, 4, 1'b0, 1'b1, 1, 5, 0, 1'b0);
    run_train(2, 3, 6,  1'b1, 1'b0, 0, -1, 0, 1'b0);
    run_train(5, 2, 4,  1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Random trains
    for (int i = 0; i < 8; i++) begin
      n   = $urandom_range(0, 4);
      w   = $urandom_range(0, 6);
      p   = $urandom_range(0, 20);
      dly = $urandom_range(0, 12);
      sel = 1'($urandom_range(0, 1));
      ten = 1'($urandom_range(0, 1));
      run_train(n, w, p, sel, ten, dly, -1, 0, n >= 2);
    end

    // Asynchronous reset in the middle of a pulse
    run_train(3, 4, 10, 1'b0, 1'b1, 2, -1, 2, 1'b0);
    #2 RST_RESYNC = 1'b1;
    #1 check_eq("rst_async", 32'(sample()), 32'(mk(ST_IDLE, 0, 0, 0, 0, 0, 0)));
    m_cnt = 0;
    @(negedge CLK40);
    RST_RESYNC = 1'b0;
    run_train(0, 1, 2, 1'b0, 1'b0, 0, -1, 0, 1'b0);

    // PLS_CNT preset to 4094, then wrap
    for (int i = 0; i < 16; i++) run_train(255, 1, 0, 1'b0, 1'b0, 0, -1, 0, 1'b0);
    run_train(14, 1, 0, 1'b1, 1'b0, 0, -1, 0, 1'b0);
    check_eq("cnt_preset", 32'(bus.PLS_CNT), 32'd4094);
    run_train(2, 1, 0, 1'b0, 1'b0, 0, -1, 0, 1'b0);
    check_eq("cnt_wrap", 32'(bus.PLS_CNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calib_pulse_gen.md
CALIB_PULSE_GEN -- requirements
Module: calib_pulse_gen

Interface
REQ-001 Parameter: TMR, 0, 1 = triplicate all state registers with bitwise majority vote; 0 = single copy.
REQ-002 CLK40  input  1  40 MHz system clock; all logic on rising edge.
REQ-003 RST_RESYNC  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  one-cycle request to begin a pulse train.
REQ-005 ABORT  input  1  terminates any train in progress.
REQ-006 SEL  input  1  output select: 0 = INJ_PLS, 1 = EXT_PLS.
REQ-007 NPULSE  input  8  number of pulses in the train.
REQ-008 WIDTH  input  4  pulse high time, in clocks.
REQ-009 PERIOD  input  12  rising-edge to rising-edge spacing, in clocks.
REQ-010 TRG_EN  input  1  enables a trigger pulse after each calibration pulse.
REQ-011 TRG_DLY  input  8  delay from pulse rise to TRG_OUT, in clocks.
REQ-012 INJ_PLS  output  1  injection pulse, registered, to the differential output buffer.
REQ-013 EXT_PLS  output  1  external pulse, registered, to the differential output buffer.
REQ-014 TRG_OUT  output  1  one-cycle trigger, registered.
REQ-015 BUSY  output  1  high while a train is active.
REQ-016 DONE  output  1  one-cycle strobe at normal train completion.
REQ-017 PLS_CNT  output  12  count of pulses issued.

Function
REQ-018 States: IDLE, HIGH, LOW, TWAIT, FIN.
REQ-019 In IDLE, START latches SEL, NPULSE, WIDTH, PERIOD, TRG_EN and TRG_DLY; later input changes have no effect until the next train.
REQ-020 START outside IDLE is ignored.
REQ-021 Latency: the selected output rises on the first clock after the START cycle; the state is HIGH.
REQ-022 WIDTH = 0 is treated as 1.
REQ-023 An effective PERIOD below WIDTH+1 is clamped to WIDTH+1, guaranteeing at least one low clock.
REQ-024 The output stays high for WIDTH clocks, then goes to LOW; the next pulse rises exactly PERIOD clocks after the previous rise.
REQ-025 The unselected output stays 0 throughout the train.
REQ-026 After the NPULSE-th pulse falls: go to TWAIT if a trigger is pending, otherwise to FIN.
REQ-027 FIN asserts DONE for one clock and returns to IDLE.
REQ-028 NPULSE = 0: no pulse is issued; START goes directly to FIN, so DONE occurs 1 clock after START.
REQ-029 With TRG_EN = 1, TRG_OUT is high for one clock, TRG_DLY clocks after each pulse rise.
REQ-030 TRG_DLY = 0 makes TRG_OUT coincide with the rising cycle.
REQ-031 The trigger delay counter restarts on every pulse rise; a pending trigger is discarded if the next pulse rises first.
REQ-032 PLS_CNT increments by 1 on each pulse rise, for either output.
REQ-033 PLS_CNT wraps from 4095 to 0.
REQ-034 PLS_CNT is not cleared by START.
REQ-035 ABORT in any state: next clock is IDLE, all pulse and trigger outputs are 0, BUSY is 0, and DONE is not asserted.
REQ-036 ABORT has priority over START in the same cycle.
REQ-037 BUSY = 1 in HIGH, LOW and TWAIT; BUSY = 0 in IDLE and FIN.

Reset
REQ-038 RST_RESYNC forces state IDLE and all outputs to 0, including PLS_CNT = 12'h000 and all latched configuration.
REQ-039 Reset asserted mid-train aborts the train immediately, asynchronously, with no DONE.
REQ-040 After reset release, the first START is accepted normally.

Structure
REQ-041 Shared package calib_pkg holds:
- state encoding;
- SEL constants SEL_INJ = 0 and SEL_EXT = 1;
- width constants for NPULSE, WIDTH, PERIOD, TRG_DLY and PLS_CNT.
REQ-042 One sub-module, tmr_vote: a parameterised-width bitwise 2-of-3 majority voter, instantiated per triplicated register when TMR = 1.
REQ-043 With TMR = 1, each replica's next state is computed from the voted value.

Verification
REQ-044 NPULSE=3, WIDTH=2, PERIOD=10, SEL=0, TRG_EN=0: INJ_PLS high on clocks 1-2, 11-12 and 21-22 after START; EXT_PLS stays 0; DONE at clock 24; PLS_CNT = 3.
REQ-045 NPULSE=1, WIDTH=1, PERIOD=5, TRG_EN=1, TRG_DLY=6, SEL=1: EXT_PLS high at clock 1; TRG_OUT high at clock 7; DONE at clock 8; BUSY high on clocks 1-7.
REQ-046 NPULSE=4, WIDTH=8, PERIOD=3: effective period is 9; rises at clocks 1, 10, 19 and 28.
REQ-047 ABORT at clock 5 of a train with NPULSE=10: outputs 0 and BUSY 0 at clock 6; no DONE; a second START is accepted.
REQ-048 PLS_CNT preset to 4094 via a train of NPULSE=255 repeated, then 2 more pulses: PLS_CNT = 0.
REQ-049 RST_RESYNC pulsed mid-pulse: all outputs 0 in the same cycle; NPULSE=0 START afterwards gives DONE 1 clock later.
